// File: rtl/load_store_unit.sv
// Load/store initiator between the EXU and the data-memory req/gnt/rvalid port.
// Word-straddling accesses are issued as two aligned transactions and merged on return.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t state, next_state;

  logic        accept, bad, split_in;
  logic [2:0]  size_in;
  logic        we_q, err_q, split_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, word0_q, word1_q;
  logic [1:0]  k;
  logic [2:0]  hi_shift;
  logic [3:0]  lanes;
  logic [31:0] shifted, ext;

  assign accept = req_valid && req_ready && (MemRd || MemWr);
  assign bad    = (MemRd && MemWr) || (MemOp == 3'b011) || (MemOp == 3'b110) ||
                  (MemOp == 3'b111) || (MemWr && MemOp[2]);

  always_comb begin
    case (MemOp[1:0])
      2'b00:   size_in = 3'd1;
      2'b01:   size_in = 3'd2;
      default: size_in = 3'd4;
    endcase
  end
  assign split_in = ({1'b0, addr[1:0]} + size_in) > 3'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= MemWr;
        err_q   <= bad;
        split_q <= split_in && !bad;
        op_q    <= MemOp;
        addr_q  <= addr;
        wdata_q <= wdata;
        word0_q <= '0;
        word1_q <= '0;
      end
      if (state == WAIT0 && mem_rvalid) word0_q <= mem_rdata;
      if (state == WAIT1 && mem_rvalid) word1_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)     next_state = bad ? RESP : REQ0;
      REQ0:    if (mem_gnt)    next_state = WAIT0;
      WAIT0:   if (mem_rvalid) next_state = split_q ? REQ1 : RESP;
      REQ1:    if (mem_gnt)    next_state = WAIT1;
      WAIT1:   if (mem_rvalid) next_state = RESP;
      RESP:                    next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  assign k        = addr_q[1:0];
  assign hi_shift = 3'd4 - {1'b0, k};

  always_comb begin
    case (op_q[1:0])
      2'b00:   lanes = 4'b0001;
      2'b01:   lanes = 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  // Phase 0 bytes sit above lane k, phase 1 bytes continue from lane 0; one shift realigns both.
  assign shifted = 32'({word1_q, word0_q} >> {k, 3'b000});

  always_comb begin
    case (op_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'b0, shifted[7:0]};
      3'b101:  ext = {16'b0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    rdata      = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      REQ0: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q) begin
          mem_wdata = wdata_q << {k, 3'b000};
          mem_wmask = {4'b0000, 4'(lanes << k)};
        end
      end
      REQ1: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
        if (we_q) begin
          mem_wdata = wdata_q >> {hi_shift, 3'b000};
          mem_wmask = {4'b0000, 4'(lanes >> hi_shift)};
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) rdata = ext;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected memory requests and responses are queued
// when a request is driven, and popped as the unit presents them.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        MemRd = 1'b0, MemWr = 1'b0;
  logic [2:0]  MemOp = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic we; logic [31:0] d; logic [7:0] m; } mreq_t;
  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;

  mreq_t       mq[$];
  resp_t       rq[$];
  logic [31:0] wq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [7:0] m);
    mq.push_back('{a: a, we: we, d: d, m: m});
  endtask

  task automatic exp_resp(input logic [31:0] r, input logic err, input int lat);
    rq.push_back('{rdata: r, err: err, lat: lat});
  endtask

  // Drives one request from an IDLE cycle and plays the memory with gdly wait cycles before each grant.
  task automatic txn(input string name, input logic rd, input logic wr, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input int gdly);
    int cyc, wcnt;
    bit pend, fresh, done;
    mreq_t cur, e;
    resp_t r;
    chk({name, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; addr = a; wdata = wd;
    cyc = 0; wcnt = 0; pend = 0; fresh = 1; done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (resp_valid) begin
        if (rq.size() == 0) chk({name, ".unexpected_resp"}, 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk({name, ".rdata"}, rdata, r.rdata);
          chk({name, ".err"}, {31'b0, resp_err}, {31'b0, r.err});
          chk({name, ".latency"}, cyc, r.lat);
        end
        done = 1;
      end else if (mem_req) begin
        if (fresh) begin
          if (mq.size() == 0) chk({name, ".unexpected_mem_req"}, 32'd1, 32'd0);
          else begin
            e = mq.pop_front();
            chk({name, ".mem_addr"}, mem_addr, e.a);
            chk({name, ".mem_we"}, {31'b0, mem_we}, {31'b0, e.we});
            chk({name, ".mem_wdata"}, mem_wdata, e.d);
            chk({name, ".mem_wmask"}, {24'b0, mem_wmask}, {24'b0, e.m});
          end
          cur = '{a: mem_addr, we: mem_we, d: mem_wdata, m: mem_wmask};
          fresh = 0;
          wcnt = 0;
        end else begin
          chk({name, ".hold_addr"}, mem_addr, cur.a);
          chk({name, ".hold_wdata"}, mem_wdata, cur.d);
          chk({name, ".hold_ctl"}, {23'b0, mem_we, mem_wmask}, {23'b0, cur.we, cur.m});
        end
        if (wcnt == gdly) begin
          mem_gnt = 1'b1;
          pend = 1;
          fresh = 1;
        end else wcnt++;
      end else if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata = (wq.size() != 0) ? wq.pop_front() : 32'h0;
        pend = 0;
      end
    end
    if (!done) chk({name, ".timeout"}, 32'd0, 32'd1);
    chk({name, ".mem_queue_drained"}, mq.size(), 32'd0);
    @(posedge clk); #1;
    chk({name, ".resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wmask", {24'b0, mem_wmask}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    exp_mem(32'h80000010, 1'b0, 32'h0, 8'h00); wq.push_back(32'hDEADBEEF);
    exp_resp(32'hDEADBEEF, 1'b0, 3);
    txn("ld_word", 1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 0);

    exp_mem(32'h80000000, 1'b0, 32'h0, 8'h00); wq.push_back(32'h11F23344);
    exp_resp(32'hFFFFFFF2, 1'b0, 3);
    txn("ld_byte_s", 1'b1, 1'b0, 3'b000, 32'h80000002, 32'h0, 0);

    exp_mem(32'h80000000, 1'b0, 32'h0, 8'h00); wq.push_back(32'h11F23344);
    exp_resp(32'h000000F2, 1'b0, 3);
    txn("ld_byte_u", 1'b1, 1'b0, 3'b100, 32'h80000002, 32'h0, 0);

    exp_mem(32'h80000000, 1'b1, 32'hDD000000, 8'h08);
    exp_mem(32'h80000004, 1'b1, 32'h00AABBCC, 8'h07);
    exp_resp(32'h0, 1'b0, 5);
    txn("st_word_split", 1'b0, 1'b1, 3'b010, 32'h80000003, 32'hAABBCCDD, 0);

    exp_mem(32'h80000004, 1'b0, 32'h0, 8'h00); wq.push_back(32'h80123456);
    exp_mem(32'h80000008, 1'b0, 32'h0, 8'h00); wq.push_back(32'hABCDEF12);
    exp_resp(32'h00001280, 1'b0, 11);
    txn("ld_half_split_wait", 1'b1, 1'b0, 3'b001, 32'h80000007, 32'h0, 3);

    exp_mem(32'h10000000, 1'b1, 32'h3456A500, 8'h02);
    exp_resp(32'h0, 1'b0, 3);
    txn("st_byte_k1", 1'b0, 1'b1, 3'b000, 32'h10000001, 32'h123456A5, 0);

    exp_mem(32'h20000000, 1'b1, 32'hEF000000, 8'h08);
    exp_mem(32'h20000004, 1'b1, 32'h000000BE, 8'h01);
    exp_resp(32'h0, 1'b0, 7);
    txn("st_half_split", 1'b0, 1'b1, 3'b001, 32'h20000003, 32'h0000BEEF, 1);

    exp_mem(32'h30000000, 1'b0, 32'h0, 8'h00); wq.push_back(32'h80017F00);
    exp_resp(32'h00008001, 1'b0, 3);
    txn("ld_half_u", 1'b1, 1'b0, 3'b101, 32'h30000002, 32'h0, 0);

    exp_mem(32'h30000000, 1'b0, 32'h0, 8'h00); wq.push_back(32'h80017F00);
    exp_resp(32'hFFFF8001, 1'b0, 3);
    txn("ld_half_s", 1'b1, 1'b0, 3'b001, 32'h30000002, 32'h0, 0);

    exp_resp(32'h0, 1'b1, 1);
    txn("err_op011", 1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0, 0);
    exp_resp(32'h0, 1'b1, 1);
    txn("err_rd_wr", 1'b1, 1'b1, 3'b010, 32'h80000000, 32'h0, 0);
    exp_resp(32'h0, 1'b1, 1);
    txn("err_st_u", 1'b0, 1'b1, 3'b100, 32'h80000000, 32'h12345678, 0);

    exp_mem(32'hFFFFFFFC, 1'b0, 32'h0, 8'h00); wq.push_back(32'h1234ABCD);
    exp_mem(32'h00000000, 1'b0, 32'h0, 8'h00); wq.push_back(32'h98765678);
    exp_resp(32'h56781234, 1'b0, 5);
    txn("ld_word_wrap", 1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);

    // Reset while a request is pending: mem_req must fall without a clock edge.
    req_valid = 1'b1; MemRd = 1'b1; MemWr = 1'b0; MemOp = 3'b010; addr = 32'h40000000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_req0.mem_req_before", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_req0.mem_req_async", {31'b0, mem_req}, 32'd0);
    chk("rst_req0.req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset in WAIT0, then a stray rvalid while idle must not produce a response.
    req_valid = 1'b1; addr = 32'h50000004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wait0.mem_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_wait0.in_wait", {30'b0, mem_req, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait0.req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait0.no_resp", {30'b0, resp_valid, mem_req}, 32'd0);
      @(posedge clk); #1;
    end

    exp_mem(32'h50000008, 1'b0, 32'h0, 8'h00); wq.push_back(32'hCAFEF00D);
    exp_resp(32'hCAFEF00D, 1'b0, 3);
    txn("after_reset", 1'b1, 1'b0, 3'b010, 32'h50000008, 32'h0, 0);

    chk("resp_queue_drained", rq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory interface: accepts one load or store per transaction from the execute stage and drives word-aligned requests with byte masks to the data memory over a req/gnt/rvalid handshake. It returns sign- or zero-extended load data. Misaligned accesses that cross a word boundary are split into two word transactions and merged internally. It sits between the EXU and the data-memory responder, and has one transaction outstanding at most.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-low.
- `clk` input 1: sole clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: EXU request valid.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `MemRd` input 1: request is a load.
- `MemWr` input 1: request is a store.
- `MemOp` input 3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores use 000/001/010.
- `addr` input 32: byte address, any alignment.
- `wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: illegal request; valid with `resp_valid`.
- `rdata` output 32: extended load data; 0 for stores and errors.
- `mem_req` output 1: memory request valid.
- `mem_gnt` input 1: memory accepts the request this cycle.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: word-aligned address; bits [1:0] are always 00.
- `mem_wdata` output 32: lane-shifted store data.
- `mem_wmask` output 8: byte-lane enables in [3:0]; [7:4] always 0.
- `mem_rvalid` input 1: read data or write acknowledge.
- `mem_rdata` input 32: little-endian word.

## Operation
- Size: 000/100 = 1 byte, 001/101 = 2 bytes, 010 = 4 bytes. Offset k = `addr[1:0]`.
- Acceptance: a request is accepted when `req_valid & req_ready & (MemRd | MemWr)`. In the accept cycle, all request fields are latched.
- Errors:
  - Condition: `MemRd & MemWr`, `MemOp` in {011, 110, 111}, or a store with `MemOp[2]` = 1.
  - Response: go to RESP with `resp_err` = 1, `rdata` = 0, and no memory access.
- Split rule: the access is split when k + size > 4.
- Phase 0:
  - Address: `addr & ~3`.
  - Mask: (((1<<size)-1)<<k) & 4'hF.
  - Write data: `wdata` << 8k.
- Phase 1 (split only):
  - Address: (`addr & ~3`) + 4, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
  - Mask: ((1<<size)-1) >> (4-k).
  - Write data: `wdata` >> 8(4-k).
- Read masks: on reads, `mem_wmask` = 0.
- Read merge:
  - Phase 0 supplies the low (4-k) bytes from lanes k..3, or fewer if unsplit.
  - Phase 1 supplies the next bytes from lanes 0 up.
  - The result is extended per `MemOp`: sign from bit 7/15 for 000/001, zero for 100/101.
- States:
  - IDLE: `req_ready` = 1. On accept, go to ERR_RESP (RESP) or REQ0.
  - REQ0: `mem_req` = 1. Go to WAIT0 on `mem_gnt`; otherwise hold.
  - WAIT0: on `mem_rvalid`, capture `mem_rdata`, then go to REQ1 if split, else RESP.
  - REQ1: `mem_req` = 1 with phase-1 fields. Go to WAIT1 on `mem_gnt`.
  - WAIT1: on `mem_rvalid`, merge, then go to RESP.
  - RESP: `resp_valid` = 1 for one cycle, then IDLE.
- Ignored inputs: `mem_rvalid` outside WAIT0/WAIT1, and `mem_gnt` outside REQ0/REQ1.

## Timing
- Reset values: state IDLE, `req_ready` = 1 (combinational from state), all other outputs 0.
- Reset mid-operation: `rst` low at any point forces IDLE immediately. `mem_req` deasserts asynchronously, and the in-flight access is abandoned without a response.
- Outputs: `mem_*` and `resp_*` are registered or decoded from state only, with no combinational path from `mem_gnt`/`mem_rvalid` to outputs.
- Request hold: `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` stay stable while `mem_req` = 1 and `mem_gnt` = 0.
- Response spacing: `mem_rvalid` is accepted no earlier than the cycle after the grant.
- Aligned latency: accept at T, `mem_req` at T+1 (gnt at T+1), rvalid at T+2, `resp_valid` at T+3.
- Split latency: minimum T+5.
- Error latency: `resp_valid` at T+1.
- Throughput: after RESP, the next accept can occur no earlier than the following IDLE cycle. Minimum spacing is 4 cycles aligned, 6 split.

## Test plan
- Aligned word load:
  - Stimulus: `addr` = 0x80000010, `MemOp` = 010; memory returns 0xDEADBEEF with zero-wait gnt.
  - Required response: `mem_addr` = 0x80000010, `rdata` = 0xDEADBEEF, `resp_valid` at T+3.
- Signed and unsigned byte load, same memory word 0x11F2_3344:
  - `addr` = 0x80000002, `MemOp` = 000: `rdata` = 0xFFFFFFF2.
  - `addr` = 0x80000002, `MemOp` = 100: `rdata` = 0x000000F2.
- Split word store:
  - Stimulus: `addr` = 0x80000003, `wdata` = 0xAABBCCDD.
  - Phase 0: `mem_addr` = 0x80000000, mask 0x08, `mem_wdata` = 0xDD000000.
  - Phase 1: `mem_addr` = 0x80000004, mask 0x07, `mem_wdata` = 0x00AABBCC.
- Split half load with wait states:
  - Stimulus: `addr` = 0x80000007, `MemOp` = 001; `mem_gnt` delayed 3 cycles; words 0x80xxxxxx then 0xxxxxxx12.
  - Required response: fields held stable while waiting; `rdata` = 0x00001280.
- Illegal requests:
  - `MemOp` = 011: `resp_valid` and `resp_err` at T+1, `mem_req` never asserted.
  - `MemRd` = `MemWr` = 1: same response.
  - Store with `MemOp` = 100: same response.
- Reset and wrap-around:
  - Reset in WAIT0: `rst` low drops `mem_req`, no `resp_valid`; a late `mem_rvalid` in IDLE is ignored; the next request completes normally.
  - Address wrap: `addr` = 0xFFFFFFFE word load makes phase 1 `mem_addr` = 0x00000000.
